// File: rtl/tiny_yolo_stream_pkg.sv
// Shared types for the M00_AXIS stream scheduler: FSM state enum, debug
// readback encoding and producer index.
package tiny_yolo_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_GRANT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  typedef enum logic {
    PROD_P0 = 1'b0,
    PROD_P1 = 1'b1
  } prod_idx_e;

  function automatic logic [7:0] fsm_code(input sched_state_e s);
    return {5'd0, s};
  endfunction

  function automatic prod_idx_e other_prod(input prod_idx_e p);
    return (p == PROD_P0) ? PROD_P1 : PROD_P0;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: holds a producer for up to BURST_LEN pushes,
// rotating early when the granted side idles while the other has data.
module rr_arbiter_2
  import tiny_yolo_stream_pkg::*;
#(
  parameter int BURST_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       active,
  input  logic [1:0] valid,
  input  logic       push,
  output logic       grant_next,
  output logic       any_valid
);

  localparam int BW = $clog2(BURST_LEN + 1);

  prod_idx_e     ptr_q, ptr_d, grant_q, grant_d;
  logic [BW-1:0] burst_q, burst_d, burst_inc;
  logic          rel;

  function automatic prod_idx_e pick(input prod_idx_e pref, input logic [1:0] v);
    prod_idx_e alt;
    alt = other_prod(pref);
    if (v[pref]) return pref;
    else if (v[alt]) return alt;
    else return pref;
  endfunction

  assign any_valid  = |valid;
  assign grant_next = grant_d;

  // Grant selection, burst counting and pointer rotation
  always_comb begin
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    burst_inc = burst_q + {{(BW-1){1'b0}}, push};
    rel       = (burst_inc == BW'(BURST_LEN)) ||
                (!valid[grant_q] && valid[other_prod(grant_q)]);
    if (arm) begin
      if (any_valid) begin
        grant_d = pick(ptr_q, valid);
        burst_d = {BW{1'b0}};
      end else begin
        grant_d = grant_q;
      end
    end else if (active) begin
      // Rotation re-grants in the same cycle so a busy pair never bubbles
      if (rel) begin
        ptr_d   = other_prod(grant_q);
        grant_d = pick(other_prod(grant_q), valid);
        burst_d = {BW{1'b0}};
      end else begin
        burst_d = burst_inc;
      end
    end else begin
      burst_d = burst_q;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= PROD_P0;
      grant_q <= PROD_P0;
      burst_q <= {BW{1'b0}};
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/tiny_yolo_stream_scheduler.sv
// Job-level controller for the M00_AXIS output path: arbitrates P0/P1 onto the
// FIFO write port, programs the beat count and reports job completion.
module tiny_yolo_stream_scheduler
  import tiny_yolo_stream_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 128,
  parameter int BURST_LEN            = 16
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic                            I_START,
  input  logic [31:0]                     I_LENGTH,
  output logic                            O_BUSY,
  output logic                            O_DONE,
  output logic                            O_ERR,
  input  logic                            P0_VALID,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] P0_DATA,
  output logic                            P0_READY,
  input  logic                            P1_VALID,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] P1_DATA,
  output logic                            P1_READY,
  output logic                            FIFO_IN_QUEUE,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] FIFO_IN_DATA,
  input  logic                            FIFO_ALMOST_FULL,
  output logic [31:0]                     NO_OF_TRANSACTION,
  input  logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  input  logic                            M_AXIS_TLAST,
  output logic [7:0]                      FSM_SCHED
);

  sched_state_e                    state_q, state_d;
  logic [31:0]                     len_q, len_d, pushed_q, pushed_d, beat_q, beat_d;
  logic                            err_q, err_d, done_q, done_d, busy_q, busy_d;
  logic                            p0_ready_q, p0_ready_d, p1_ready_q, p1_ready_d;
  logic                            fifo_queue_q, fifo_queue_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [7:0]                      fsm_q, fsm_d;
  logic                            p0_hs, p1_hs, push, in_job, bad_tlast, start_busy;
  logic                            grant_next, any_valid;

  assign p0_hs      = p0_ready_q & P0_VALID;
  assign p1_hs      = p1_ready_q & P1_VALID;
  assign push       = p0_hs | p1_hs;
  assign in_job     = (state_q == ST_ARM) || (state_q == ST_GRANT) || (state_q == ST_DRAIN);
  assign bad_tlast  = in_job & M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST &
                      (beat_q != len_q - 32'd1);
  assign start_busy = I_START & (state_q != ST_IDLE);

  rr_arbiter_2 #(.BURST_LEN(BURST_LEN)) u_arb (
    .clk       (M_AXIS_ACLK),
    .rst       (M_AXIS_ARESET),
    .arm       (state_q == ST_ARM),
    .active    (state_q == ST_GRANT),
    .valid     ({P1_VALID, P0_VALID}),
    .push      (push),
    .grant_next(grant_next),
    .any_valid (any_valid)
  );

  // Job FSM, counters and next values of all registered outputs
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pushed_d = pushed_q + {31'd0, push};
    beat_d   = beat_q + {31'd0, in_job & M_AXIS_TVALID & M_AXIS_TREADY};
    err_d    = err_q | bad_tlast | start_busy;
    case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          if (I_LENGTH != 32'd0) begin
            state_d  = ST_ARM;
            len_d    = I_LENGTH;
            pushed_d = 32'd0;
            beat_d   = 32'd0;
            err_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM:   state_d = any_valid ? ST_GRANT : ST_ARM;
      ST_GRANT: state_d = (pushed_d == len_q) ? ST_DRAIN : ST_GRANT;
      ST_DRAIN: state_d = (beat_q == len_q) ? ST_DONE : ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // READY is registered, so it reflects this cycle's ALMOST_FULL one cycle later
    p0_ready_d   = (state_d == ST_GRANT) && (grant_next == PROD_P0) &&
                   !FIFO_ALMOST_FULL && (pushed_d < len_d);
    p1_ready_d   = (state_d == ST_GRANT) && (grant_next == PROD_P1) &&
                   !FIFO_ALMOST_FULL && (pushed_d < len_d);
    fifo_queue_d = push;
    fifo_data_d  = p1_hs ? P1_DATA : (p0_hs ? P0_DATA : fifo_data_q);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    fsm_d        = fsm_code(state_d);
  end

  // State and output registers
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q      <= ST_IDLE;
      len_q        <= 32'd0;
      pushed_q     <= 32'd0;
      beat_q       <= 32'd0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      p0_ready_q   <= 1'b0;
      p1_ready_q   <= 1'b0;
      fifo_queue_q <= 1'b0;
      fifo_data_q  <= {C_M_AXIS_TDATA_WIDTH{1'b0}};
      fsm_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pushed_q     <= pushed_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      p0_ready_q   <= p0_ready_d;
      p1_ready_q   <= p1_ready_d;
      fifo_queue_q <= fifo_queue_d;
      fifo_data_q  <= fifo_data_d;
      fsm_q        <= fsm_d;
    end
  end

  assign O_BUSY            = busy_q;
  assign O_DONE            = done_q;
  assign O_ERR             = err_q;
  assign P0_READY          = p0_ready_q;
  assign P1_READY          = p1_ready_q;
  assign FIFO_IN_QUEUE     = fifo_queue_q;
  assign FIFO_IN_DATA      = fifo_data_q;
  assign NO_OF_TRANSACTION = len_q;
  assign FSM_SCHED         = fsm_q;

endmodule

// File: tb/tb_tiny_yolo_stream_scheduler.sv
// Scoreboard bench for tiny_yolo_stream_scheduler: expected FIFO words are
// queued per job and compared as the DUT writes them.
module tb_tiny_yolo_stream_scheduler;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         areset, i_start, p0_valid, p1_valid, almost_full;
  logic         tvalid, tready, tlast;
  logic [31:0]  i_length;
  logic [W-1:0] p0_data, p1_data;
  logic         o_busy, o_done, o_err, p0_ready, p1_ready, fifo_queue;
  logic [W-1:0] fifo_data;
  logic [31:0]  no_of_trans;
  logic [7:0]   fsm_sched;

  int n_checks = 0;
  int n_pass   = 0;
  int job = 0, p0_idx = 0, p1_idx = 0, pushes_obs = 0, beats_sent = 0;
  int done_cnt = 0, tlast_at = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  tiny_yolo_stream_scheduler #(.C_M_AXIS_TDATA_WIDTH(W), .BURST_LEN(16)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(areset), .I_START(i_start), .I_LENGTH(i_length),
    .O_BUSY(o_busy), .O_DONE(o_done), .O_ERR(o_err),
    .P0_VALID(p0_valid), .P0_DATA(p0_data), .P0_READY(p0_ready),
    .P1_VALID(p1_valid), .P1_DATA(p1_data), .P1_READY(p1_ready),
    .FIFO_IN_QUEUE(fifo_queue), .FIFO_IN_DATA(fifo_data), .FIFO_ALMOST_FULL(almost_full),
    .NO_OF_TRANSACTION(no_of_trans), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST(tlast), .FSM_SCHED(fsm_sched)
  );

  task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [W-1:0] mkword(input logic p, input int j, input int idx);
    logic [31:0] tag;
    tag = p ? 32'hB1B1_0001 : 32'hA0A0_0000;
    return {tag, 32'(j), 32'h5A5A_5A5A, 32'(idx)};
  endfunction

  task automatic exp_seq(input logic p, input int from, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mkword(p, job, from + i));
  endtask

  // One clock: producers and the stream sink react to the handshakes of this edge
  task automatic tick();
    logic hs0, hs1, bt;
    logic [W-1:0] exp_w;
    hs0 = p0_ready & p0_valid;
    hs1 = p1_ready & p1_valid;
    bt  = tvalid & tready;
    @(posedge clk); #1;
    if (hs0 === 1'b1) p0_idx++;
    if (hs1 === 1'b1) p1_idx++;
    if (bt) beats_sent++;
    if (fifo_queue === 1'b1) begin
      pushes_obs++;
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : {W{1'b1}};
      check_val("fifo_data", fifo_data, exp_w);
    end
    if (o_done === 1'b1) done_cnt++;
    p0_data = mkword(1'b0, job, p0_idx);
    p1_data = mkword(1'b1, job, p1_idx);
    tvalid  = (pushes_obs > beats_sent);
    tlast   = tvalid && (beats_sent == tlast_at);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, o_busy, 0);
    check_val({tag, "_done"}, o_done, 0);
    check_val({tag, "_err"}, o_err, 0);
    check_val({tag, "_p0rdy"}, p0_ready, 0);
    check_val({tag, "_p1rdy"}, p1_ready, 0);
    check_val({tag, "_queue"}, fifo_queue, 0);
    check_val({tag, "_fdata"}, fifo_data, 0);
    check_val({tag, "_ntrans"}, no_of_trans, 0);
    check_val({tag, "_fsm"}, fsm_sched, 0);
  endtask

  task automatic start_job(input string tag, input int len, input int tl_at);
    job++;
    p0_idx = 0; p1_idx = 0; pushes_obs = 0; beats_sent = 0; done_cnt = 0;
    tlast_at = tl_at;
    tvalid = 1'b0; tlast = 1'b0;
    p0_data = mkword(1'b0, job, 0);
    p1_data = mkword(1'b1, job, 0);
    i_start = 1'b1; i_length = 32'(len);
    tick();
    i_start = 1'b0;
    check_val({tag, "_ntrans"}, no_of_trans, 32'(len));
    check_val({tag, "_fsm_arm"}, fsm_sched, 8'd1);
    check_val({tag, "_err_clr"}, o_err, 0);
    check_val({tag, "_busy"}, o_busy, 1);
  endtask

  task automatic wait_pushes(input string tag, input int n);
    int cyc = 0;
    while (pushes_obs < n && cyc < 500) begin tick(); cyc++; end
    check_val({tag, "_pushes_reached"}, (pushes_obs >= n), 1);
  endtask

  task automatic wait_done(input string tag, input int len, input logic exp_err);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin tick(); cyc++; end
    check_val({tag, "_done_seen"}, done_cnt, 1);
    check_val({tag, "_beats"}, beats_sent, len);
    check_val({tag, "_pushes"}, pushes_obs, len);
    check_val({tag, "_err"}, o_err, exp_err);
    check_val({tag, "_busy_in_done"}, o_busy, 1);
    check_val({tag, "_fsm_done"}, fsm_sched, 8'd4);
    check_val({tag, "_exp_left"}, exp_q.size(), 0);
    tick();
    check_val({tag, "_done_1cyc"}, o_done, 0);
    check_val({tag, "_busy_off"}, o_busy, 0);
    check_val({tag, "_fsm_idle"}, fsm_sched, 8'd0);
    repeat (3) tick();
    check_val({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    int af_cnt;
    areset = 1'b1; i_start = 1'b0; i_length = 32'd0; p0_valid = 1'b0; p1_valid = 1'b0;
    almost_full = 1'b0; tvalid = 1'b0; tready = 1'b1; tlast = 1'b0;
    p0_data = '0; p1_data = '0;
    repeat (3) tick();
    check_reset_outputs("rst");
    areset = 1'b0;
    tick();

    // Test 1: P0 only, 32 words in order
    p0_valid = 1'b1;
    start_job("t1", 32, 31);
    exp_seq(1'b0, 0, 32);
    wait_done("t1", 32, 1'b0);

    // Test 2: both producers busy; fresh reset puts the RR pointer on P0
    areset = 1'b1; tick(); areset = 1'b0; tick();
    p1_valid = 1'b1;
    start_job("t2", 64, 63);
    exp_seq(1'b0, 0, 16); exp_seq(1'b1, 0, 16);
    exp_seq(1'b0, 16, 16); exp_seq(1'b1, 16, 16);
    wait_done("t2", 64, 1'b0);
    p1_valid = 1'b0;

    // Test 3: ALMOST_FULL held mid-burst
    start_job("t3", 32, 31);
    exp_seq(1'b0, 0, 32);
    wait_pushes("t3", 5);
    almost_full = 1'b1;
    af_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fifo_queue === 1'b1) af_cnt++;
      if (i == 1) check_val("t3_ready_low", p0_ready, 0);
    end
    check_val("t3_af_pushes_le1", (af_cnt <= 1), 1);
    almost_full = 1'b0;
    wait_done("t3", 32, 1'b0);

    // Test 4: zero-length start, then a start while busy
    i_start = 1'b1; i_length = 32'd0;
    tick();
    i_start = 1'b0;
    check_val("t4_len0_err", o_err, 1);
    check_val("t4_len0_fsm", fsm_sched, 8'd0);
    check_val("t4_len0_busy", o_busy, 0);
    check_val("t4_len0_ntrans", no_of_trans, 32'd32);
    start_job("t4", 32, 31);
    exp_seq(1'b0, 0, 32);
    wait_pushes("t4", 3);
    check_val("t4_fsm_grant", fsm_sched, 8'd2);
    i_start = 1'b1; i_length = 32'd5;
    tick();
    i_start = 1'b0;
    check_val("t4_busy_start_err", o_err, 1);
    check_val("t4_busy_start_ntrans", no_of_trans, 32'd32);
    wait_done("t4", 32, 1'b1);

    // Test 5: early TLAST on beat 10
    start_job("t5", 32, 10);
    exp_seq(1'b0, 0, 32);
    wait_done("t5", 32, 1'b1);

    // Test 6: reset mid-GRANT, then a fresh job
    start_job("t6", 32, 31);
    exp_seq(1'b0, 0, 32);
    wait_pushes("t6", 4);
    check_val("t6_fsm_grant", fsm_sched, 8'd2);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    tick();
    start_job("t6b", 32, 31);
    exp_seq(1'b0, 0, 32);
    wait_done("t6b", 32, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
